// File: rtl/alu_cmd_issuer_pkg.sv
// ---------------------------------------------------------------------------
// alu_package
//   Types and constants shared by the ALU command issuer and its FIFO.
//   - alu_pkt_t     : one complete ALU command packet
//   - issue_state_t : issuer FSM states
//   - alu_latency() : cycles from issue until the ALU result is valid
// ---------------------------------------------------------------------------
`ifndef OP_WIDTH
`define OP_WIDTH 8
`endif
`ifndef CMD_WIDTH
`define CMD_WIDTH 4
`endif

package alu_package;

    localparam int OP_W  = `OP_WIDTH;
    localparam int CMD_W = `CMD_WIDTH;

    localparam logic [CMD_W-1:0] CMD_MUL_INC   = CMD_W'(9);
    localparam logic [CMD_W-1:0] CMD_MUL_SHIFT = CMD_W'(10);

    // INP_VALID encoding meaning "no operand valid": such packets are dropped.
    localparam logic [1:0] INP_NONE = 2'b00;

    typedef struct packed {
        logic             mode;
        logic [CMD_W-1:0] cmd;
        logic [OP_W-1:0]  opa;
        logic [OP_W-1:0]  opb;
        logic             cin;
        logic [1:0]       inp_valid;
    } alu_pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } issue_state_t;

    // Multiplies (arithmetic mode, CMD 9/10) take two cycles; all else one.
    function automatic logic [1:0] alu_latency(input logic             mode,
                                               input logic [CMD_W-1:0] cmd);
        return (mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHIFT)) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
//   Synchronous FIFO of alu_pkt_t, DEPTH entries (power of two).
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     push, wr_data   : write request (ignored when full)
//     pop,  rd_data   : read request (ignored when empty); rd_data shows head
//     full, empty     : status flags
//     count           : occupancy, one bit wider than the pointers
// ---------------------------------------------------------------------------
module alu_cmd_fifo
    import alu_package::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  alu_pkt_t               wr_data,
    input  logic                   pop,
    output alu_pkt_t               rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    alu_pkt_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap mod DEPTH; only the count's extra MSB separates full from empty.
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are meaningful, so stale data is never seen.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
//   Buffers ALU command packets and issues them one at a time, holding each
//   off until the previous command's result has been produced.
//   Ports:
//     CLK, RST                : clock, asynchronous active-low reset
//     CE                      : issue-side clock enable (shared with the ALU)
//     IN_VALID / IN_READY     : producer handshake; IN_* are the packet fields
//     INP_VALID, MODE, CMD,
//     OPA, OPB, CIN           : registered drive to the ALU
//     RES_VALID               : ALU outputs belong to the last issued command
//     BUSY                    : work queued or in flight
//     COUNT                   : FIFO occupancy
// ---------------------------------------------------------------------------
module alu_cmd_issuer
    import alu_package::*;
#(
    parameter int DW    = `OP_WIDTH,
    parameter int CW    = `CMD_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CE,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic                   IN_MODE,
    input  logic [CW-1:0]          IN_CMD,
    input  logic [DW-1:0]          IN_OPA,
    input  logic [DW-1:0]          IN_OPB,
    input  logic                   IN_CIN,
    input  logic [1:0]             IN_INP_VALID,
    output logic [1:0]             INP_VALID,
    output logic                   MODE,
    output logic [CW-1:0]          CMD,
    output logic [DW-1:0]          OPA,
    output logic [DW-1:0]          OPB,
    output logic                   CIN,
    output logic                   RES_VALID,
    output logic                   BUSY,
    output logic [$clog2(DEPTH):0] COUNT
);

    alu_pkt_t     in_pkt;
    alu_pkt_t     head;
    alu_pkt_t     drive_q, drive_d;
    issue_state_t state_q, state_d;
    logic [1:0]   wait_q, wait_d;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic         head_live;

    assign in_pkt.mode      = IN_MODE;
    assign in_pkt.cmd       = IN_CMD;
    assign in_pkt.opa       = IN_OPA;
    assign in_pkt.opb       = IN_OPB;
    assign in_pkt.cin       = IN_CIN;
    assign in_pkt.inp_valid = IN_INP_VALID;

    // Refuse packets while reset is held, not just while full.
    assign IN_READY = RST && !fifo_full;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .push    (IN_VALID && IN_READY),
        .wr_data (in_pkt),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (COUNT)
    );

    // A head that can be issued back-to-back from WAIT; 00 heads are left
    // for IDLE to discard.
    assign head_live = !fifo_empty && (head.inp_valid != INP_NONE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            wait_q  <= 2'd0;
            drive_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            drive_q <= drive_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        wait_d  = wait_q;
        drive_d = drive_q;
        pop     = 1'b0;

        // With CE low everything holds, including any pending pop.
        if (CE) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (head.inp_valid != INP_NONE) begin
                            drive_d = head;
                            state_d = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_d            = alu_latency(drive_q.mode, drive_q.cmd);
                    drive_d.inp_valid = INP_NONE;
                    state_d           = ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_q == 2'd1) begin
                        wait_d = 2'd0;
                        if (head_live) begin
                            pop     = 1'b1;
                            drive_d = head;
                            state_d = ST_ISSUE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        wait_d = wait_q - 2'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign RES_VALID = CE && (state_q == ST_WAIT) && (wait_q == 2'd1);
    assign BUSY      = !fifo_empty || (state_q != ST_IDLE);

    assign INP_VALID = drive_q.inp_valid;
    assign MODE      = drive_q.mode;
    assign CMD       = drive_q.cmd;
    assign OPA       = drive_q.opa;
    assign OPB       = drive_q.opb;
    assign CIN       = drive_q.cin;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_issuer
//   Self-checking bench for alu_cmd_issuer: directed scenarios followed by
//   randomized traffic, compared every cycle against a transaction-level
//   reference model (packet queue + enabled-cycle age of the in-flight op).
// ---------------------------------------------------------------------------
module tb_alu_cmd_issuer;
    import alu_package::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic       in_valid;
    logic       in_ready;
    alu_pkt_t   in_pkt;
    logic [1:0] inp_valid;
    logic       mode;
    logic [3:0] cmd;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       cin;
    logic       res_valid;
    logic       busy;
    logic [3:0] count;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.DW(8), .CW(4), .DEPTH(DEPTH)) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .CE           (ce),
        .IN_VALID     (in_valid),
        .IN_READY     (in_ready),
        .IN_MODE      (in_pkt.mode),
        .IN_CMD       (in_pkt.cmd),
        .IN_OPA       (in_pkt.opa),
        .IN_OPB       (in_pkt.opb),
        .IN_CIN       (in_pkt.cin),
        .IN_INP_VALID (in_pkt.inp_valid),
        .INP_VALID    (inp_valid),
        .MODE         (mode),
        .CMD          (cmd),
        .OPA          (opa),
        .OPB          (opb),
        .CIN          (cin),
        .RES_VALID    (res_valid),
        .BUSY         (busy),
        .COUNT        (count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_q   : packets accepted but not yet taken by the issuer
    // m_cur : last packet issued (its fields stay on the ALU bus)
    // m_t   : enabled cycles since that issue (0 = issue cycle), -1 = nothing in flight
    alu_pkt_t m_q[$];
    alu_pkt_t m_cur;
    int       m_t;
    int       m_lat;
    bit       m_in_rst;

    function automatic int lat_of(input alu_pkt_t p);
        return (p.mode && (p.cmd == 4'd9 || p.cmd == 4'd10)) ? 2 : 1;
    endfunction

    function automatic alu_pkt_t mk(input logic m, input logic [3:0] c, input logic [7:0] a,
                                    input logic [7:0] b, input logic ci, input logic [1:0] iv);
        alu_pkt_t p;
        p.mode = m; p.cmd = c; p.opa = a; p.opb = b; p.cin = ci; p.inp_valid = iv;
        return p;
    endfunction

    task automatic mdl_reset();
        m_q.delete();
        m_cur = '0;
        m_t   = -1;
        m_lat = 1;
    endtask

    // Advance the model across one rising edge using the inputs of that cycle.
    task automatic mdl_step();
        bit       accept;
        alu_pkt_t h;
        accept = in_valid && (m_q.size() < DEPTH);
        if (ce) begin
            if (m_t < 0) begin
                if (m_q.size() > 0) begin
                    h = m_q.pop_front();
                    if (h.inp_valid != 2'b00) begin
                        m_cur = h; m_lat = lat_of(h); m_t = 0;
                    end
                end
            end else if (m_t < m_lat) begin
                m_t++;
            end else if (m_q.size() > 0 && m_q[0].inp_valid != 2'b00) begin
                m_cur = m_q.pop_front(); m_lat = lat_of(m_cur); m_t = 0;
            end else begin
                m_t = -1;
            end
        end
        if (accept) m_q.push_back(in_pkt);
    endtask

    task automatic compare_all();
        check("inp_valid", inp_valid, (m_t == 0) ? m_cur.inp_valid : 2'b00);
        check("alu_fields", {mode, cmd, opa, opb, cin},
              {m_cur.mode, m_cur.cmd, m_cur.opa, m_cur.opb, m_cur.cin});
        check("res_valid", res_valid, ce && (m_t >= 1) && (m_t == m_lat));
        check("count", count, m_q.size());
        check("in_ready", in_ready, !m_in_rst && (m_q.size() < DEPTH));
        check("busy", busy, (m_q.size() != 0) || (m_t >= 0));
    endtask

    // One clock cycle: drive at negedge, check, let the edge happen, step model.
    task automatic cycle(input bit c, input bit v, input alu_pkt_t p);
        @(negedge clk);
        ce = c; in_valid = v; in_pkt = p;
        #1 compare_all();
        @(posedge clk);
        mdl_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0);
    endtask

    // Assert reset between edges, check its asynchronous effect, hold, release.
    task automatic do_reset(input int hold);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; ce = 1'b1;
        mdl_reset(); m_in_rst = 1'b1;
        #1 compare_all();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1 compare_all();
        end
        @(negedge clk);
        rst_n = 1'b1; m_in_rst = 1'b0;
        #1 compare_all();
        @(posedge clk);
        mdl_step();
    endtask

    alu_pkt_t rp;

    initial begin
        rst_n = 1'b1; ce = 1'b0; in_valid = 1'b0; in_pkt = '0;
        mdl_reset(); m_in_rst = 1'b0;

        // Reset state, then release.
        #2 rst_n = 1'b0; m_in_rst = 1'b1;
        #1 compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; m_in_rst = 1'b0; ce = 1'b1;
        #1 compare_all();
        @(posedge clk);
        mdl_step();

        // Single ADD.
        cycle(1'b1, 1'b1, mk(1'b1, 4'd0, 8'h0F, 8'h01, 1'b0, 2'b11));
        idle(5);

        // Multiply followed by a queued ADD (next issue at T+3).
        cycle(1'b1, 1'b1, mk(1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 2'b11));
        cycle(1'b1, 1'b1, mk(1'b1, 4'd0, 8'd5, 8'd6, 1'b1, 2'b11));
        idle(8);

        // Fill with CE low; the 9th push must be refused.
        for (int i = 0; i < 9; i++)
            cycle(1'b0, 1'b1, mk(i[0], (i[0] ? 4'd10 : 4'(i)), 8'(i * 17), 8'(i + 1), i[1], 2'b11));
        idle(30);

        // Drop of a 00 entry between two live ones.
        cycle(1'b1, 1'b1, mk(1'b1, 4'd0, 8'h21, 8'h12, 1'b0, 2'b11));
        cycle(1'b1, 1'b1, mk(1'b1, 4'd0, 8'h77, 8'h77, 1'b1, 2'b00));
        cycle(1'b1, 1'b1, mk(1'b0, 4'd0, 8'hF0, 8'h3C, 1'b0, 2'b11));
        idle(8);

        // CE stall for 3 cycles right after an issue.
        cycle(1'b1, 1'b1, mk(1'b1, 4'd0, 8'h44, 8'h01, 1'b0, 2'b11));
        for (int k = 0; k < 10 && m_t != 0; k++) idle(1);
        check("stall_issue_reached", m_t, 0);
        idle(1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, '0);
        idle(4);

        // Reset during WAIT of a multiply with three entries queued.
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, mk(1'b1, (i == 0) ? 4'd9 : 4'd1, 8'(i + 2), 8'(i + 3), 1'b0, 2'b11));
        idle(2);
        check("mid_op_in_wait", (m_t >= 1) && (m_q.size() == 3), 1'b1);
        do_reset(2);
        idle(6);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rp.mode      = 1'($urandom_range(0, 1));
            rp.cmd       = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 4'd9 : 4'd10)
                                                       : 4'($urandom_range(0, 15));
            rp.opa       = 8'($urandom);
            rp.opb       = 8'($urandom);
            rp.cin       = 1'($urandom_range(0, 1));
            rp.inp_valid = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 599) == 0)
                do_reset($urandom_range(0, 2));
            else
                cycle($urandom_range(0, 9) < 8, $urandom_range(0, 2) != 0, rp);
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
